// File: rtl/simon_pkg.sv
// Shared types and default timing constants for the Simon game datapath blocks.
package simon_pkg;

  typedef logic [1:0] colour_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_RD,
    ON,
    OFF,
    DONE
  } playback_state_t;

  localparam int TICK_DIV_DEFAULT = 500000;
  localparam int BASE_ON_TICKS    = 40;
  localparam int OFF_TICKS        = 20;
  localparam int STEP_TICKS       = 5;
  localparam int MIN_ON_TICKS     = 8;
  localparam int MAX_ROUNDS       = 32;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV cycles, phase-aligned to clear.
module tick_prescaler #(
  parameter int TICK_DIV = simon_pkg::TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/playback_sequencer.sv
// Plays the stored colour sequence on the LEDs at the latched game speed.
// Define PLAYBACK_FINAL_GAP_EN to keep a full OFF gap after the last colour before DONE.
module playback_sequencer #(
  parameter int TICK_DIV      = simon_pkg::TICK_DIV_DEFAULT,
  parameter int BASE_ON_TICKS = simon_pkg::BASE_ON_TICKS,
  parameter int OFF_TICKS     = simon_pkg::OFF_TICKS,
  parameter int STEP_TICKS    = simon_pkg::STEP_TICKS,
  parameter int MIN_ON_TICKS  = simon_pkg::MIN_ON_TICKS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [5:0] length,
  input  logic [2:0] speed,
  output logic [4:0] rd_addr,
  input  logic [1:0] rd_data,
  output logic [3:0] led,
  output logic       busy,
  output logic       done
);
  import simon_pkg::*;

  playback_state_t state_q, state_d;
  logic [4:0] idx_q;
  logic [5:0] len_q;
  logic [7:0] on_q;
  logic [7:0] tcnt_q;
  colour_t    colour_q;
  logic       tick, clear, last, on_done, off_done;

  function automatic logic [5:0] clamp_len(input logic [5:0] len);
    if (len > 6'(MAX_ROUNDS)) return 6'(MAX_ROUNDS);
    return len;
  endfunction

  // Signed 8-bit so high speeds go negative instead of wrapping before the floor.
  function automatic logic [7:0] calc_on(input logic [2:0] spd);
    logic signed [7:0] raw;
    raw = $signed(8'(BASE_ON_TICKS)) - $signed(8'(spd)) * $signed(8'(STEP_TICKS));
    if (raw < $signed(8'(MIN_ON_TICKS))) return 8'(MIN_ON_TICKS);
    return $unsigned(raw);
  endfunction

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .tick  (tick)
  );

  always_comb begin
    state_d  = state_q;
    last     = ({1'b0, idx_q} + 6'd1) >= len_q;
    on_done  = tick && (tcnt_q == on_q - 8'd1);
    off_done = tick && (tcnt_q == 8'(OFF_TICKS - 1));
    case (state_q)
      IDLE:    if (start) state_d = (clamp_len(length) == 6'd0) ? DONE : FETCH;
      FETCH:   state_d = WAIT_RD;
      WAIT_RD: state_d = ON;
      ON: if (on_done) begin
`ifdef PLAYBACK_FINAL_GAP_EN
        state_d = OFF;
`else
        state_d = last ? DONE : OFF;
`endif
      end
      OFF:     if (off_done) state_d = last ? DONE : FETCH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
    // Timers restart on every entry to a timed state so durations are exact.
    clear = (state_d != state_q) && ((state_d == ON) || (state_d == OFF));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d != IDLE) begin
        idx_q <= '0;
      end else if (state_q == OFF && state_d == FETCH) begin
        idx_q <= idx_q + 5'd1;
      end
      if (clear) begin
        tcnt_q <= '0;
      end else if (tick) begin
        tcnt_q <= tcnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && start && !abort) begin
      len_q <= clamp_len(length);
      on_q  <= calc_on(speed);
    end
    if (state_q == WAIT_RD) colour_q <= rd_data;
  end

  always_comb begin
    led = '0;
    if (state_q == ON) led = 4'd1 << colour_q;
  end

  assign rd_addr = idx_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_playback_sequencer.sv
// Directed bench for playback_sequencer with TICK_DIV=4 and a RAM holding 2,0,3,1,...
module tb_playback_sequencer;

`ifdef PLAYBACK_FINAL_GAP_EN
  localparam int GAP = 80;
`else
  localparam int GAP = 0;
`endif

  logic       clk = 1'b0;
  logic       reset, start, abort;
  logic [5:0] length;
  logic [2:0] speed;
  logic [4:0] rd_addr;
  logic [1:0] rd_data;
  logic [3:0] led;
  logic       busy, done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  playback_sequencer #(.TICK_DIV(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .length  (length),
    .speed   (speed),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .led     (led),
    .busy    (busy),
    .done    (done)
  );

  logic [1:0] ram [0:31];
  logic [1:0] pat [4] = '{2'd2, 2'd0, 2'd3, 2'd1};
  initial for (int i = 0; i < 32; i++) ram[i] = pat[i % 4];
  always @(posedge clk) rd_data <= ram[rd_addr];

  always @(posedge clk) cyc <= cyc + 1;

  int         ev_cyc[$];
  logic [3:0] ev_led[$];
  int         done_cyc[$];
  int         busy_fall[$];
  int         max_addr = 0;
  logic [3:0] led_prev = 4'd0;
  logic       busy_prev = 1'b0;

  always @(negedge clk) begin
    if (led !== led_prev) begin
      ev_cyc.push_back(cyc);
      ev_led.push_back(led);
      led_prev = led;
    end
    if (done === 1'b1) done_cyc.push_back(cyc);
    if (busy_prev === 1'b1 && busy === 1'b0) busy_fall.push_back(cyc);
    busy_prev = busy;
    if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
  end

  task automatic pulse_start(input logic [5:0] len, input logic [2:0] spd, output int s);
    @(negedge clk);
    length = len;
    speed  = spd;
    start  = 1'b1;
    s      = cyc;
    ev_cyc.delete();
    ev_led.delete();
    done_cyc.delete();
    busy_fall.delete();
    max_addr = 0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int i;
    for (i = 0; i < limit && done_cyc.size() == 0; i++) @(negedge clk);
    if (done_cyc.size() == 0) begin
      total++; bad++;
      $display("FAIL wait_done timeout after %0d cycles", limit);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; abort = 1'b0; length = '0; speed = '0;
    repeat (3) @(negedge clk);
    total++; if (led !== 4'd0) begin bad++; $display("FAIL reset_led got=%b want=0000", led); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (rd_addr !== 5'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", rd_addr); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_play3;
    int s;
    int exp_c[6] = '{3, 163, 245, 405, 487, 647};
    logic [3:0] exp_l[6] = '{4'b0100, 4'b0000, 4'b0001, 4'b0000, 4'b1000, 4'b0000};
    pulse_start(6'd3, 3'd0, s);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL play3_busy_t1 got=%b want=1", busy); end
    total++; if (led !== 4'd0) begin bad++; $display("FAIL play3_led_t1 got=%b want=0000", led); end
    wait_done(1200);
    total++; if (ev_cyc.size() != 6) begin bad++; $display("FAIL play3_events got=%0d want=6", ev_cyc.size()); end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (i >= ev_cyc.size() || ev_cyc[i] != s + exp_c[i] || ev_led[i] !== exp_l[i]) begin
        bad++;
        $display("FAIL play3_ev%0d got=%0d/%b want=%0d/%b", i,
                 (i < ev_cyc.size()) ? ev_cyc[i] - s : -1,
                 (i < ev_led.size()) ? ev_led[i] : 4'bxxxx, exp_c[i], exp_l[i]);
      end
    end
    total++; if (done_cyc.size() != 1) begin bad++; $display("FAIL play3_done_count got=%0d want=1", done_cyc.size()); end
    total++;
    if (done_cyc.size() == 0 || done_cyc[0] != s + 647 + GAP) begin
      bad++; $display("FAIL play3_done_cyc got=%0d want=%0d", (done_cyc.size() > 0) ? done_cyc[0] - s : -1, 647 + GAP);
    end
    total++;
    if (busy_fall.size() != 1 || busy_fall[0] != s + 648 + GAP) begin
      bad++; $display("FAIL play3_busy_fall got=%0d want=%0d", (busy_fall.size() > 0) ? busy_fall[0] - s : -1, 648 + GAP);
    end
  endtask

  task automatic test_speed_clamp;
    int s;
    pulse_start(6'd1, 3'd7, s);
    wait_done(400);
    total++;
    if (ev_cyc.size() != 2 || ev_cyc[0] != s + 3 || ev_led[0] !== 4'b0100 || ev_cyc[1] != s + 35) begin
      bad++; $display("FAIL clamp_on_window got=%0d..%0d want=3..35",
                      (ev_cyc.size() > 0) ? ev_cyc[0] - s : -1, (ev_cyc.size() > 1) ? ev_cyc[1] - s : -1);
    end
    total++;
    if (done_cyc.size() != 1 || done_cyc[0] != s + 35 + GAP) begin
      bad++; $display("FAIL clamp_done got=%0d want=%0d", (done_cyc.size() > 0) ? done_cyc[0] - s : -1, 35 + GAP);
    end
  endtask

  task automatic test_empty;
    int s;
    int ons;
    logic [3:0] last_on;
    pulse_start(6'd0, 3'd0, s);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL empty_done_t1 got=%b want=1", done); end
    repeat (5) @(negedge clk);
    total++; if (ev_cyc.size() != 0) begin bad++; $display("FAIL empty_led_events got=%0d want=0", ev_cyc.size()); end
    total++;
    if (busy_fall.size() != 1 || busy_fall[0] != s + 2) begin
      bad++; $display("FAIL empty_busy_fall got=%0d want=2", (busy_fall.size() > 0) ? busy_fall[0] - s : -1);
    end
    pulse_start(6'd40, 3'd7, s);
    wait_done(5000);
    ons = 0; last_on = 4'd0;
    foreach (ev_led[i]) if (ev_led[i] != 4'd0) begin ons++; last_on = ev_led[i]; end
    total++; if (ons != 32) begin bad++; $display("FAIL len40_colours got=%0d want=32", ons); end
    total++; if (max_addr != 31) begin bad++; $display("FAIL len40_max_addr got=%0d want=31", max_addr); end
    total++; if (last_on !== 4'b0010) begin bad++; $display("FAIL len40_last_led got=%b want=0010", last_on); end
    total++;
    if (done_cyc.size() != 1 || done_cyc[0] != s + 3569 + GAP) begin
      bad++; $display("FAIL len40_done got=%0d want=%0d", (done_cyc.size() > 0) ? done_cyc[0] - s : -1, 3569 + GAP);
    end
  endtask

  task automatic test_abort;
    int s;
    pulse_start(6'd3, 3'd7, s);
    while (cyc < s + 130) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++; if (led !== 4'd0) begin bad++; $display("FAIL abort_led got=%b want=0000", led); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
    total++;
    if (ev_cyc.size() < 3 || ev_cyc[2] != s + 117 || ev_led[2] !== 4'b0001) begin
      bad++; $display("FAIL abort_second_on got=%0d want=117", (ev_cyc.size() > 2) ? ev_cyc[2] - s : -1);
    end
    repeat (400) @(negedge clk);
    total++; if (done_cyc.size() != 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", done_cyc.size()); end
    pulse_start(6'd1, 3'd0, s);
    total++; if (rd_addr !== 5'd0) begin bad++; $display("FAIL replay_addr got=%0d want=0", rd_addr); end
    wait_done(400);
    total++;
    if (ev_cyc.size() != 2 || ev_cyc[0] != s + 3 || ev_led[0] !== 4'b0100) begin
      bad++; $display("FAIL replay_first got=%0d/%b want=3/0100",
                      (ev_cyc.size() > 0) ? ev_cyc[0] - s : -1, (ev_led.size() > 0) ? ev_led[0] : 4'bxxxx);
    end
    total++;
    if (done_cyc.size() != 1 || done_cyc[0] != s + 163 + GAP) begin
      bad++; $display("FAIL replay_done got=%0d want=%0d", (done_cyc.size() > 0) ? done_cyc[0] - s : -1, 163 + GAP);
    end
  endtask

  task automatic test_reset_precedence;
    int s;
    int ons;
    pulse_start(6'd3, 3'd7, s);
    while (cyc < s + 160) @(negedge clk);
    total++; if (rd_addr !== 5'd1) begin bad++; $display("FAIL prec_pre_addr got=%0d want=1", rd_addr); end
    reset = 1'b1; abort = 1'b1;
    @(negedge clk);
    reset = 1'b0; abort = 1'b0;
    total++;
    if (led !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || rd_addr !== 5'd0) begin
      bad++; $display("FAIL prec_outputs got=%b/%b/%b/%0d want=0000/0/0/0", led, busy, done, rd_addr);
    end
    repeat (300) @(negedge clk);
    total++; if (done_cyc.size() != 0) begin bad++; $display("FAIL prec_no_done got=%0d want=0", done_cyc.size()); end

    pulse_start(6'd2, 3'd7, s);
    while (cyc < s + 20) @(negedge clk);
    length = 6'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(600);
    ons = 0;
    foreach (ev_led[i]) if (ev_led[i] != 4'd0) ons++;
    total++; if (ons != 2) begin bad++; $display("FAIL busy_start_colours got=%0d want=2", ons); end
    total++;
    if (done_cyc.size() != 1 || done_cyc[0] != s + 149 + GAP) begin
      bad++; $display("FAIL busy_start_done got=%0d want=%0d", (done_cyc.size() > 0) ? done_cyc[0] - s : -1, 149 + GAP);
    end
  endtask

  initial begin
    test_reset();
    test_play3();
    test_speed_clamp();
    test_empty();
    test_abort();
    test_reset_precedence();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
